// File: rtl/seq_divider.sv
// Sequential 4-bit unsigned restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero completes at the accepting edge with quotient 4'hF and remainder = dividend.
module seq_divider (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] dividend,
   input  logic [3:0] divisor,
   output logic       busy,
   output logic       done,
   output logic [3:0] quotient,
   output logic [3:0] remainder,
   output logic       div_by_zero
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e     state_q;
   logic [3:0] dvd_q;
   logic [3:0] dvs_q;
   logic [1:0] cnt_q;
   logic [3:0] rem_q;
   logic [3:0] quo_q;

   logic [4:0] part;
   logic [5:0] sum;
   logic       carry;
   logic [3:0] rem_d;
   logic       unused_trial_msb;

   // ~cnt_q selects dividend bit 3,2,1,0 on steps 0..3.
   always_comb begin
      part             = {rem_q, dvd_q[~cnt_q]};
      sum              = {1'b0, part} + {1'b0, ~{1'b0, dvs_q}} + 6'd1;
      carry            = sum[5];
      unused_trial_msb = sum[4];
      rem_d            = carry ? sum[3:0] : part[3:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         dvd_q       <= 4'd0;
         dvs_q       <= 4'd0;
         cnt_q       <= 2'd0;
         rem_q       <= 4'd0;
         quo_q       <= 4'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= 4'd0;
         remainder   <= 4'd0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  dvd_q <= dividend;
                  dvs_q <= divisor;
                  cnt_q <= 2'd0;
                  rem_q <= 4'd0;
                  quo_q <= 4'd0;
                  if (divisor == 4'd0) begin
                     quotient    <= 4'hF;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                     busy        <= 1'b0;
                     state_q     <= StDone;
                  end else begin
                     quotient    <= 4'd0;
                     remainder   <= 4'd0;
                     div_by_zero <= 1'b0;
                     busy        <= 1'b1;
                     state_q     <= StRun;
                  end
               end else begin
                  state_q <= StIdle;
               end
            end
            StRun: begin
               rem_q <= rem_d;
               quo_q <= {quo_q[2:0], carry};
               cnt_q <= cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  quotient  <= {quo_q[2:0], carry};
                  remainder <= rem_d;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state_q   <= StDone;
               end
            end
            default: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider against an arithmetic reference model.
module tb_seq_divider;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] dividend;
   logic [3:0] divisor;
   logic       busy;
   logic       done;
   logic [3:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;

   int vectors = 0;
   int miscompares = 0;

   seq_divider dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // Advance past the next rising edge; inputs change and outputs are sampled here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, ".busy"}, 8'(busy), 8'd0);
      check({tag, ".done"}, 8'(done), 8'd0);
      check({tag, ".quotient"}, 8'(quotient), 8'd0);
      check({tag, ".remainder"}, 8'(remainder), 8'd0);
      check({tag, ".dbz"}, 8'(div_by_zero), 8'd0);
   endtask

   // Called just after the accepting edge; checks timing and results for a/b.
   task automatic wait_result(input string tag, input logic [3:0] a, input logic [3:0] b);
      logic [3:0] eq, er;
      logic       ez;
      if (b == 4'd0) begin
         eq = 4'hF; er = a; ez = 1'b1;
      end else begin
         eq = a / b; er = a % b; ez = 1'b0;
         for (int i = 0; i < 4; i++) begin
            check({tag, ".busy_run"}, 8'(busy), 8'd1);
            check({tag, ".done_run"}, 8'(done), 8'd0);
            tick();
         end
      end
      check({tag, ".done"}, 8'(done), 8'd1);
      check({tag, ".busy"}, 8'(busy), 8'd0);
      check({tag, ".quotient"}, 8'(quotient), 8'(eq));
      check({tag, ".remainder"}, 8'(remainder), 8'(er));
      check({tag, ".dbz"}, 8'(div_by_zero), 8'(ez));
   endtask

   task automatic start_and_wait(input string tag, input logic [3:0] a, input logic [3:0] b);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      wait_result(tag, a, b);
   endtask

   // Results must hold in IDLE with no further done pulse.
   task automatic check_hold(input string tag, input logic [3:0] eq, input logic [3:0] er,
                             input logic ez);
      tick();
      check({tag, ".done_idle"}, 8'(done), 8'd0);
      check({tag, ".busy_idle"}, 8'(busy), 8'd0);
      check({tag, ".q_hold"}, 8'(quotient), 8'(eq));
      check({tag, ".r_hold"}, 8'(remainder), 8'(er));
      check({tag, ".z_hold"}, 8'(div_by_zero), 8'(ez));
   endtask

   initial begin
      logic [3:0] a, b;
      rst = 1'b1; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
      tick();
      tick();
      check_zero_outputs("reset");

      // Reset wins over a coincident start.
      start = 1'b1; dividend = 4'd7; divisor = 4'd2;
      tick();
      check_zero_outputs("rst_start");
      rst = 1'b0; start = 1'b0;
      tick();
      check_zero_outputs("post_reset");

      start_and_wait("d13_3", 4'd13, 4'd3);
      check_hold("d13_3", 4'd4, 4'd1, 1'b0);
      start_and_wait("d15_1", 4'd15, 4'd1);
      check_hold("d15_1", 4'd15, 4'd0, 1'b0);
      start_and_wait("d5_7", 4'd5, 4'd7);
      start_and_wait("d15_15", 4'd15, 4'd15);
      check_hold("d15_15", 4'd1, 4'd0, 1'b0);

      start_and_wait("d9_0", 4'd9, 4'd0);
      check_hold("d9_0", 4'hF, 4'd9, 1'b1);

      // Start during RUN is ignored.
      dividend = 4'd12; divisor = 4'd5; start = 1'b1;
      tick();
      dividend = 4'd3; divisor = 4'd1;
      for (int i = 0; i < 4; i++) begin
         check("ign.busy_run", 8'(busy), 8'd1);
         check("ign.done_run", 8'(done), 8'd0);
         if (i == 2) start = 1'b0;
         tick();
      end
      check("ign.done", 8'(done), 8'd1);
      check("ign.quotient", 8'(quotient), 8'd2);
      check("ign.remainder", 8'(remainder), 8'd2);
      tick();

      // Back-to-back: start accepted in DONE launches a new RUN immediately.
      start_and_wait("b2b_first", 4'd12, 4'd5);
      dividend = 4'd8; divisor = 4'd3; start = 1'b1;
      tick();
      start = 1'b0;
      wait_result("b2b_8_3", 4'd8, 4'd3);

      // Zero divisor straight from DONE gives a fresh pulse.
      dividend = 4'd6; divisor = 4'd0; start = 1'b1;
      tick();
      start = 1'b0;
      wait_result("b2b_6_0", 4'd6, 4'd0);
      check_hold("b2b_6_0", 4'hF, 4'd6, 1'b1);

      // Reset on the 2nd RUN edge aborts with no done pulse.
      dividend = 4'd14; divisor = 4'd3; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_zero_outputs("abort");
      for (int i = 0; i < 6; i++) begin
         tick();
         check("abort.no_done", 8'(done), 8'd0);
         check("abort.no_busy", 8'(busy), 8'd0);
      end

      for (int n = 0; n < 60; n++) begin
         a = 4'($urandom_range(15));
         b = (n % 8 == 0) ? 4'd0 : 4'($urandom_range(15));
         start_and_wait("rand", a, b);
         if (n % 3 == 0) begin
            if (b == 4'd0) check_hold("rand", 4'hF, a, 1'b1);
            else           check_hold("rand", a / b, a % b, 1'b0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
